// File: rtl/bus_arbiter_2to1_pkg.sv
// Shared definitions for the 2:1 round-robin bus arbiter: FSM state encodings and the
// default datapath width.
package bus_arbiter_2to1_pkg;

  localparam int unsigned DefWidth = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/Multiplexer.sv
// Shared 2:1 word multiplexer of the datapath; choice = 0 selects option1, 1 selects option2.
module Multiplexer #(
  parameter int unsigned WIDTH = bus_arbiter_2to1_pkg::DefWidth
) (
  input  logic [WIDTH-1:0] option1,
  input  logic [WIDTH-1:0] option2,
  input  logic             choice,
  output logic [WIDTH-1:0] result
);

  assign result = choice ? option2 : option1;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Round-robin burst arbiter in front of the shared 2:1 multiplexer; registers the selected
// word and hands it to a single consumer over a valid/ready handshake.
module bus_arbiter_2to1
  import bus_arbiter_2to1_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [1:0]       req_last,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_source,
  output logic             out_last,
  input  logic             out_ready,
  output logic             choice
);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_beat_cnt;
  logic             r_rr_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_source;
  logic             r_out_last;

  logic [WIDTH-1:0] w_mux_result;
  logic             w_slot_free;
  logic             w_idx;
  logic             w_accept;
  logic             w_forced;
  logic             w_release;

  Multiplexer #(
    .WIDTH(WIDTH)
  ) u_mux (
    .option1(req_data0),
    .option2(req_data1),
    .choice (choice),
    .result (w_mux_result)
  );

  assign choice      = (r_state == StGrant1);
  assign w_idx       = choice;
  assign w_slot_free = !r_out_valid || out_ready;

  always_comb begin
    req_ready    = 2'b00;
    req_ready[0] = (r_state == StGrant0) && req_valid[0] && w_slot_free;
    req_ready[1] = (r_state == StGrant1) && req_valid[1] && w_slot_free;
  end

  assign w_accept  = |req_ready;
  assign w_forced  = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_release = req_last[w_idx] || w_forced;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_beat_cnt   <= '0;
      r_rr_ptr     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_source <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_mux_result;
        r_out_source <= w_idx;
        r_out_last   <= w_release;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          unique case (req_valid)
            2'b01:   r_state <= StGrant0;
            2'b10:   r_state <= StGrant1;
            2'b11:   r_state <= r_rr_ptr ? StGrant1 : StGrant0;
            default: r_state <= StIdle;
          endcase
        end
        StGrant0, StGrant1: begin
          if (w_accept) begin
            if (w_release) begin
              r_beat_cnt <= '0;
              r_rr_ptr   <= ~w_idx;
              // Hand off to the other requester first; fall back to the same one, else idle.
              if (req_valid[~w_idx]) begin
                r_state <= w_idx ? StGrant0 : StGrant1;
              end else if (req_valid[w_idx]) begin
                r_state <= w_idx ? StGrant1 : StGrant0;
              end else begin
                r_state <= StIdle;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_source = r_out_source;
  assign out_last   = r_out_last;

endmodule
